bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 143 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with a leading-zero blanking mask for a seven-segment display driver.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 13,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  // Largest decimal value representable in DIGITS digits, plus one.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Refuse parameter sets whose largest input would overflow the BCD digits.
  if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_params
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic [WIDTH-1:0]  sreg;
  logic [BW-1:0]     scratch;
  logic [CW-1:0]     cnt;
  logic              last_shift;
  logic [BW-1:0]     adj;
  logic [BW-1:0]     scratch_nxt;
  logic [WIDTH-1:0]  sreg_nxt;
  logic [DIGITS-1:0] en_nxt;

  assign last_shift = (cnt == CW'(WIDTH - 1));

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags follow the state being entered so they line up with it.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt == SHIFT) busy_nxt = 1'b1;
    if (state_nxt == DONE)  done_nxt = 1'b1;
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Add-3 correction on every digit >= 5, then shift one binary bit in.
  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    scratch_nxt = {adj[BW-2:0], sreg[WIDTH-1]};
    sreg_nxt    = {sreg[WIDTH-2:0], 1'b0};
  end

  // Blanking mask: a digit is lit if it or any more significant digit is nonzero.
  always_comb begin
    logic seen;
    seen   = 1'b0;
    en_nxt = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      seen      = seen | (|scratch_nxt[4*i +: 4]);
      en_nxt[i] = seen;
    end
    en_nxt[0] = 1'b1;
  end

  // Conversion datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      scratch  <= '0;
      cnt      <= '0;
      bcd      <= '0;
      digit_en <= DIGITS'(1);
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sreg    <= bin;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          sreg    <= sreg_nxt;
          scratch <= scratch_nxt;
          cnt     <= cnt + CW'(1);
          if (last_shift) begin
            bcd      <= scratch_nxt;
            digit_en <= en_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expected results are queued at each
// accepted start and compared whenever the DUT pulses done.
module tb_bin2bcd_seq;

  localparam int unsigned WIDTH  = 13;
  localparam int unsigned DIGITS = 4;
  localparam int          LAT    = WIDTH + 1;
  localparam int          BUSYC  = WIDTH;

  typedef struct packed {
    logic [DIGITS-1:0]   en;
    logic [4*DIGITS-1:0] bcd;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   digit_en;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   done_seen  = 0;
  int   n_expected = 0;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .digit_en (digit_en)
  );

  always #5 clk = ~clk;

  // Run-away guard.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Decimal reference: digits by repeated division, mask by magnitude.
  function automatic exp_t model(input int v);
    exp_t e;
    int   r;
    r = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      e.bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.en[0] = 1'b1;
    for (int i = 1; i < int'(DIGITS); i++) e.en[i] = (v >= 10 ** i);
    return e;
  endfunction

  task automatic push_exp(input int v);
    exp_q.push_back(model(v));
    n_expected++;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("bcd", 32'(bcd), 32'(e.bcd));
        check("digit_en", 32'(digit_en), 32'(e.en));
        check("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  // Called one step after the start edge; lat counts cycles from the request cycle.
  task automatic wait_done(output int lat, output int bcyc);
    lat  = 1;
    bcyc = 0;
    while (!done && lat < 40) begin
      if (busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic run_conv(input int v);
    int lat, bcyc;
    bin   = WIDTH'(v);
    start = 1'b1;
    push_exp(v);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcyc);
    check("latency", 32'(lat), 32'(LAT));
    check("busy_cycles", 32'(bcyc), 32'(BUSYC));
  endtask

  initial begin
    int lat, bcyc, snap;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_digit_en", 32'(digit_en), 32'd1);
    rst = 1'b0;

    // Start on the very first edge after reset release.
    run_conv(0);
    run_conv(8191);
    run_conv(100);
    run_conv(9);

    // Starts during SHIFT (cycle 5) and DONE (cycle 14) are ignored.
    bin   = WIDTH'(1234);
    start = 1'b1;
    push_exp(1234);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    bin   = WIDTH'(5678);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("c14_done", 32'(done), 32'd1);
    start = 1'b1;
    @(posedge clk); #1;
    check("c15_idle_no_done", 32'(done), 32'd0);
    push_exp(5678);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcyc);
    check("restart_latency", 32'(lat), 32'(LAT));

    // Input changes after the start edge do not affect the result.
    bin   = WIDTH'(4321);
    start = 1'b1;
    push_exp(4321);
    @(posedge clk); #1;
    start = 1'b0;
    bin   = '0;
    wait_done(lat, bcyc);

    // Mid-conversion reset aborts without a done pulse.
    run_conv(1234);
    bin   = WIDTH'(999);
    start = 1'b1;
    push_exp(999);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    n_expected--;
    snap = done_seen;
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_digit_en", 32'(digit_en), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (20) begin @(posedge clk); #1; end
    check("abort_no_done", 32'(done_seen), 32'(snap));
    check("abort_bcd_hold", 32'(bcd), 32'd0);
    run_conv(42);

    // A handful of random values.
    repeat (6) run_conv(int'($urandom_range(0, 8191)));

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_seen), 32'(n_expected));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
